// File: rtl/p_div.sv
// Multi-cycle packed unsigned divider: restoring division, one step per cycle,
// all lanes in parallel, lane width selected by a one-hot pw.
module p_div (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic        rem_sel,
    input  logic [4:0]  pw,
    input  logic [31:0] crs1,
    input  logic [31:0] crs2,
    output logic [31:0] result
);

    localparam int NW = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d;
    // Holds the dividend; quotient bits shift in at each lane LSB as dividend bits leave its MSB.
    logic [31:0] dq_q, dq_d;

    logic [NW-1:0][31:0] step_rem;
    logic [NW-1:0][31:0] step_dq;
    logic [31:0]         step_rem_sel;
    logic [31:0]         step_dq_sel;
    logic [5:0]          lane_w;
    logic                pw_ok;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_width
            localparam int W = 32 >> gi;
            localparam int L = 32 / W;
            for (gj = 0; gj < L; gj++) begin : g_lane
                logic [W-1:0] rem_sh;
                logic [W-1:0] dvs;
                logic [W-1:0] diff;
                logic         ge;
                // The partial remainder is always below 2^(k) after k steps, so the
                // dropped top bit is provably zero and no W+1-bit compare is needed.
                assign rem_sh = {rem_q[gj*W +: W-1], dq_q[gj*W + W - 1]};
                assign dvs    = crs2[gj*W +: W];
                assign ge     = (rem_sh >= dvs);
                assign diff   = rem_sh - dvs;
                assign step_rem[gi][gj*W +: W] = ge ? diff : rem_sh;
                assign step_dq[gi][gj*W +: W]  = {dq_q[gj*W +: W-1], ge};
            end
        end
    endgenerate

    always_comb begin
        step_rem_sel = step_rem[0];
        step_dq_sel  = step_dq[0];
        lane_w       = 6'd32;
        case (pw)
            5'b00010: begin step_rem_sel = step_rem[1]; step_dq_sel = step_dq[1]; lane_w = 6'd16; end
            5'b00100: begin step_rem_sel = step_rem[2]; step_dq_sel = step_dq[2]; lane_w = 6'd8;  end
            5'b01000: begin step_rem_sel = step_rem[3]; step_dq_sel = step_dq[3]; lane_w = 6'd4;  end
            5'b10000: begin step_rem_sel = step_rem[4]; step_dq_sel = step_dq[4]; lane_w = 6'd2;  end
            default:  begin end
        endcase
    end

    assign pw_ok = (pw != 5'd0) && ((pw & (pw - 5'd1)) == 5'd0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    if (pw_ok) begin
                        dq_d    = crs1;
                        rem_d   = 32'd0;
                        count_d = lane_w;
                        state_d = S_RUN;
                    end else begin
                        dq_d    = 32'd0;
                        rem_d   = 32'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (!valid) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d   = step_rem_sel;
                    dq_d    = step_dq_sel;
                    count_d = count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 6'd0;
            rem_q   <= 32'd0;
            dq_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
        end
    end

    assign ready  = (state_q == S_DONE);
    assign result = ready ? (rem_sel ? rem_q : dq_q) : 32'd0;

endmodule

// File: tb/tb_p_div.sv
// Directed and short random checks of p_div: per-lane quotient/remainder,
// divide-by-zero, latency, invalid width, abort and mid-operation reset.
module tb_p_div;

    logic        clock;
    logic        reset;
    logic        valid;
    logic        ready;
    logic        rem_sel;
    logic [4:0]  pw;
    logic [31:0] crs1;
    logic [31:0] crs2;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;

    p_div dut (
        .clock   (clock),
        .reset   (reset),
        .valid   (valid),
        .ready   (ready),
        .rem_sel (rem_sel),
        .pw      (pw),
        .crs1    (crs1),
        .crs2    (crs2),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] p, input logic [31:0] a,
                                          input logic [31:0] b, input logic rs);
        int w;
        logic [31:0] r;
        case (p)
            5'b00001: w = 32;
            5'b00010: w = 16;
            5'b00100: w = 8;
            5'b01000: w = 4;
            5'b10000: w = 2;
            default:  return 32'd0;
        endcase
        r = 32'd0;
        for (int l = 0; l < 32 / w; l++) begin
            logic [63:0] m, x, y, o;
            m = (64'd1 << w) - 64'd1;
            x = ({32'd0, a} >> (l * w)) & m;
            y = ({32'd0, b} >> (l * w)) & m;
            if (y == 64'd0) o = rs ? x : m;
            else            o = rs ? (x % y) : (x / y);
            r = r | 32'(o << (l * w));
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [4:0] p);
        case (p)
            5'b00001: return 33;
            5'b00010: return 17;
            5'b00100: return 9;
            5'b01000: return 5;
            5'b10000: return 3;
            default:  return 1;
        endcase
    endfunction

    // Called just after a rising edge with the block idle; returns just after the edge
    // that ends the ready cycle. Latency counts the cycle ready is seen in.
    task automatic do_req(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b,
                          input logic rs, output logic [31:0] res, output int lat);
        int edges;
        bit got;
        valid   = 1'b1;
        pw      = p;
        crs1    = a;
        crs2    = b;
        rem_sel = rs;
        @(posedge clock);
        edges = 0;
        got   = 1'b0;
        res   = 32'hDEAD_BEEF;
        while (edges < 40) begin
            @(negedge clock);
            if (ready) begin
                got = 1'b1;
                res = result;
                break;
            end
            edges++;
        end
        lat = got ? edges + 1 : 0;
        if (!got) $display("FAIL timeout: no ready within 40 cycles (pw=%b)", p);
        @(posedge clock);
        #1;
        valid = 1'b0;
        check("ready_pulse", {31'd0, ready}, 32'd0);
    endtask

    task automatic vec(input string tag, input logic [4:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic rs, input logic [31:0] exp_res,
                       input int lat_exp);
        logic [31:0] res;
        int lat;
        do_req(p, a, b, rs, res, lat);
        $display("req %-10s pw=%b a=%08h b=%08h rs=%0d -> %08h lat=%0d", tag, p, a, b, rs, res, lat);
        check({tag, "_res"}, res, exp_res);
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    endtask

    initial begin
        bit seen;
        logic [31:0] res;
        int lat;
        logic [4:0] pw_tab [12];

        reset   = 1'b1;
        valid   = 1'b0;
        rem_sel = 1'b0;
        pw      = 5'b00001;
        crs1    = 32'd0;
        crs2    = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready",  {31'd0, ready}, 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        vec("q32",  5'b00001, 32'd100, 32'd7, 1'b0, 32'd14, 33);
        vec("r32",  5'b00001, 32'd100, 32'd7, 1'b1, 32'd2,  33);
        vec("q16",  5'b00010, 32'h0064_0009, 32'h000A_0002, 1'b0, 32'h000A_0004, 17);
        vec("r16",  5'b00010, 32'h0064_0009, 32'h000A_0002, 1'b1, 32'h0000_0001, 17);
        vec("q8z",  5'b00100, 32'h1122_3344, 32'h0002_0003, 1'b0, 32'hFF11_FF16, 9);
        vec("r8z",  5'b00100, 32'h1122_3344, 32'h0002_0003, 1'b1, 32'h1100_3302, 9);
        vec("q2",   5'b10000, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 3);
        vec("r2",   5'b10000, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1, 32'h0000_0000, 3);
        vec("bad11", 5'b00011, 32'h1234_5678, 32'h0000_0003, 1'b0, 32'd0, 1);
        vec("bad00", 5'b00000, 32'h1234_5678, 32'h0000_0003, 1'b1, 32'd0, 1);
        vec("q32z", 5'b00001, 32'hCAFE_F00D, 32'd0, 1'b0, 32'hFFFF_FFFF, 33);
        vec("r32m", 5'b00001, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'h7FFF_FFFE, 33);

        // Abort: valid low is sampled at t0+5 while running.
        valid = 1'b1; pw = 5'b00001; crs1 = 32'd1000; crs2 = 32'd3; rem_sel = 1'b0;
        @(posedge clock);
        repeat (4) @(posedge clock);
        #1;
        valid = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (ready) seen = 1'b1;
        end
        $display("req abort      ready_seen=%0d", seen);
        check("abort_noready", {31'd0, seen}, 32'd0);
        @(posedge clock);
        #1;
        // Upper lanes divide 0 by 0, giving all-ones quotients there.
        vec("q4_ab", 5'b01000, 32'h0000_0009, 32'h0000_0002, 1'b0, 32'hFFFF_FFF4, 5);
        vec("r4_ab", 5'b01000, 32'h0000_0009, 32'h0000_0002, 1'b1, 32'h0000_0001, 5);

        // Reset in the middle of a 32-bit operation.
        valid = 1'b1; pw = 5'b00001; crs1 = 32'd77; crs2 = 32'd5; rem_sel = 1'b1;
        @(posedge clock);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ready",  {31'd0, ready}, 32'd0);
        check("midrst_result", result, 32'd0);
        valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        vec("q8_pr", 5'b00100, 32'hFF80_400A, 32'h1003_0703, 1'b0, 32'h0F2A_0903, 9);
        vec("r8_pr", 5'b00100, 32'hFF80_400A, 32'h1003_0703, 1'b1, 32'h0F02_0101, 9);

        // Short random soak against the lane model.
        pw_tab = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                   5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
                   5'b00011, 5'b00000};
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  p;
            logic [31:0] a, b;
            logic        rs;
            p  = pw_tab[$urandom_range(0, 11)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0F0F_00FF) : $urandom;
            rs = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            do_req(p, a, b, rs, res, lat);
            $display("req rnd%-4d   pw=%b a=%08h b=%08h rs=%0d -> %08h lat=%0d", i, p, a, b, rs, res, lat);
            check("rnd_res", res, model(p, a, b, rs));
            check("rnd_lat", 32'(lat), 32'(exp_lat(p)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
